mem_access_stage: RTL and testbench

Memory stage of the 16-bit pipeline, sitting between the EXE/MEM register and the write-back stage. It performs loads and stores over a variable-latency SRAM request/acknowledge handshake and freezes upstream stages while an access is outstanding. It also contains the MEM/WB pipeline register that directly feeds write-back with the memory-read flag, read data, ALU result, base value and add-base flag.

---
 rtl/mem_access_stage_pkg.sv | 17 +
 rtl/mem_access_stage_if.sv | 18 +
 rtl/mem_access_stage_mem_wb_reg.sv | 52 +++++
 rtl/mem_access_stage.sv | 158 +++++++++++++++
 tb/tb_mem_access_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared widths, FSM encoding and decode helpers for the memory-access stage.
package mem_access_stage_pkg;

  localparam int WORD_LEN_C          = 16;
  localparam int REG_FILE_ADDR_LEN_C = 4;
  localparam int CNT_W               = 8;

  typedef enum logic [0:0] {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic is_mem_op(input logic valid, input logic r_en, input logic w_en);
    return valid & (r_en | w_en);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// SRAM request/acknowledge bus between the memory stage (master) and the SRAM (slave).
interface mem_access_stage_if
  import mem_access_stage_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_C
) ();

  logic                req;
  logic                we;
  logic [WORD_LEN-1:0] addr;
  logic [WORD_LEN-1:0] wdata;
  logic [WORD_LEN-1:0] rdata;
  logic                ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register: load-enabled, synchronous active-low clear.
module mem_wb_reg
  import mem_access_stage_pkg::*;
#(
  parameter int WORD_LEN     = WORD_LEN_C,
  parameter int REG_ADDR_LEN = REG_FILE_ADDR_LEN_C
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    ld,
  input  logic                    valid_d,
  input  logic                    wb_en_d,
  input  logic                    mem_r_en_d,
  input  logic                    add_base_d,
  input  logic [REG_ADDR_LEN-1:0] dest_d,
  input  logic [WORD_LEN-1:0]     alu_res_d,
  input  logic [WORD_LEN-1:0]     mem_data_d,
  input  logic [15:0]             val1_d,
  output logic                    valid_q,
  output logic                    wb_en_q,
  output logic                    mem_r_en_q,
  output logic                    add_base_q,
  output logic [REG_ADDR_LEN-1:0] dest_q,
  output logic [WORD_LEN-1:0]     alu_res_q,
  output logic [WORD_LEN-1:0]     mem_data_q,
  output logic [15:0]             val1_q
);

  // Pipeline register storage
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      valid_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      add_base_q <= 1'b0;
      dest_q     <= '0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      val1_q     <= 16'h0000;
    end else if (ld) begin
      valid_q    <= valid_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      add_base_q <= add_base_d;
      dest_q     <= dest_d;
      alu_res_q  <= alu_res_d;
      mem_data_q <= mem_data_d;
      val1_q     <= val1_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: SRAM load/store over a req/ack handshake with timeout abort,
// upstream freeze while an access is outstanding, and the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int WORD_LEN     = WORD_LEN_C,
  parameter int REG_ADDR_LEN = REG_FILE_ADDR_LEN_C,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic                    MEM_R_EN_in,
  input  logic                    MEM_W_EN_in,
  input  logic                    WB_EN_in,
  input  logic [REG_ADDR_LEN-1:0] dest_in,
  input  logic [WORD_LEN-1:0]     aluRes_in,
  input  logic [WORD_LEN-1:0]     st_val_in,
  input  logic [15:0]             val1_in,
  input  logic                    add_base_in,
  output logic                    freeze,
  mem_access_stage_if.master      sram,
  output logic                    mem_err,
  output logic                    valid_out,
  output logic                    WB_EN_out,
  output logic                    MEM_R_EN_out,
  output logic                    add_base_out,
  output logic [REG_ADDR_LEN-1:0] dest_out,
  output logic [WORD_LEN-1:0]     aluRes_out,
  output logic [WORD_LEN-1:0]     memData_out,
  output logic [15:0]             val1_out
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  mem_state_e          state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic                req_r, we_r;
  logic [WORD_LEN-1:0] addr_r, wdata_r;

  logic                mem_op_s, start_s, done_s, ld_s, freeze_s, mem_err_s;
  logic                wb_valid_s, wb_en_s;
  logic [WORD_LEN-1:0] wb_mem_data_s;

  assign mem_op_s = is_mem_op(valid_in, MEM_R_EN_in, MEM_W_EN_in);

  // Next-state, freeze/abort decode and MEM/WB input selection
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    start_s       = 1'b0;
    done_s        = 1'b0;
    ld_s          = 1'b1;
    freeze_s      = 1'b0;
    mem_err_s     = 1'b0;
    wb_valid_s    = valid_in;
    wb_en_s       = WB_EN_in & valid_in;
    wb_mem_data_s = '0;
    case (state_r)
      MEM_IDLE: begin
        if (mem_op_s) begin
          freeze_s    = 1'b1;
          start_s     = 1'b1;
          cnt_nxt_s   = 8'd0;
          wb_valid_s  = 1'b0;
          wb_en_s     = 1'b0;
          state_nxt_s = MEM_ACCESS;
        end else begin
          state_nxt_s = MEM_IDLE;
        end
      end
      MEM_ACCESS: begin
        if (sram.ack) begin
          done_s        = 1'b1;
          wb_mem_data_s = MEM_R_EN_in ? sram.rdata : '0;
          state_nxt_s   = MEM_IDLE;
        end else if (cnt_r == TIMEOUT_C) begin
          // Abort: instruction retires without write-back
          done_s      = 1'b1;
          mem_err_s   = 1'b1;
          wb_en_s     = 1'b0;
          state_nxt_s = MEM_IDLE;
        end else begin
          // Waiting: MEM/WB keeps the bubble loaded when the access started
          freeze_s  = 1'b1;
          ld_s      = 1'b0;
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = MEM_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= MEM_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // SRAM request drivers, held stable for the whole access
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (start_s) begin
      req_r   <= 1'b1;
      we_r    <= MEM_W_EN_in & ~MEM_R_EN_in;
      addr_r  <= aluRes_in;
      wdata_r <= st_val_in;
    end else if (done_s) begin
      req_r <= 1'b0;
      we_r  <= 1'b0;
    end
  end

  assign sram.req   = req_r;
  assign sram.we    = we_r;
  assign sram.addr  = addr_r;
  assign sram.wdata = wdata_r;
  assign freeze     = freeze_s;
  assign mem_err    = mem_err_s;

  mem_wb_reg #(
    .WORD_LEN     (WORD_LEN),
    .REG_ADDR_LEN (REG_ADDR_LEN)
  ) u_mem_wb_reg (
    .clk        (clk),
    .clr_n      (rst_n),
    .ld         (ld_s),
    .valid_d    (wb_valid_s),
    .wb_en_d    (wb_en_s),
    .mem_r_en_d (MEM_R_EN_in),
    .add_base_d (add_base_in),
    .dest_d     (dest_in),
    .alu_res_d  (aluRes_in),
    .mem_data_d (wb_mem_data_s),
    .val1_d     (val1_in),
    .valid_q    (valid_out),
    .wb_en_q    (WB_EN_out),
    .mem_r_en_q (MEM_R_EN_out),
    .add_base_q (add_base_out),
    .dest_q     (dest_out),
    .alu_res_q  (aluRes_out),
    .mem_data_q (memData_out),
    .val1_q     (val1_out)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=4 and hand-computed expectations.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, add_base_in;
  logic [3:0]  dest_in;
  logic [15:0] aluRes_in, st_val_in, val1_in;
  logic        freeze, mem_err;
  logic        valid_out, WB_EN_out, MEM_R_EN_out, add_base_out;
  logic [3:0]  dest_out;
  logic [15:0] aluRes_out, memData_out, val1_out;

  int checks_cnt = 0;
  int errors_cnt = 0;

  mem_access_stage_if #(.WORD_LEN(16)) sif ();

  mem_access_stage #(
    .WORD_LEN     (16),
    .REG_ADDR_LEN (4),
    .TIMEOUT      (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .MEM_R_EN_in  (MEM_R_EN_in),
    .MEM_W_EN_in  (MEM_W_EN_in),
    .WB_EN_in     (WB_EN_in),
    .dest_in      (dest_in),
    .aluRes_in    (aluRes_in),
    .st_val_in    (st_val_in),
    .val1_in      (val1_in),
    .add_base_in  (add_base_in),
    .freeze       (freeze),
    .sram         (sif),
    .mem_err      (mem_err),
    .valid_out    (valid_out),
    .WB_EN_out    (WB_EN_out),
    .MEM_R_EN_out (MEM_R_EN_out),
    .add_base_out (add_base_out),
    .dest_out     (dest_out),
    .aluRes_out   (aluRes_out),
    .memData_out  (memData_out),
    .val1_out     (val1_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic r, input logic w, input logic wb,
                           input logic [3:0] d, input logic [15:0] alu, input logic [15:0] st);
    valid_in    = v;
    MEM_R_EN_in = r;
    MEM_W_EN_in = w;
    WB_EN_in    = wb;
    dest_in     = d;
    aluRes_in   = alu;
    st_val_in   = st;
  endtask

  initial begin
    rst_n       = 1'b0;
    add_base_in = 1'b0;
    val1_in     = 16'h0000;
    sif.ack     = 1'b1;
    sif.rdata   = 16'hFFFF;
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0005, 16'h0000);

    // Reset with ack high and a pending load: everything cleared, IDLE decode only
    tick();
    tick();
    chk("rst_req", sif.req, 32'd0);
    chk("rst_valid", valid_out, 32'd0);
    chk("rst_wben", WB_EN_out, 32'd0);
    chk("rst_alu", aluRes_out, 32'd0);
    chk("rst_memerr", mem_err, 32'd0);
    chk("rst_freeze_idle_decode", freeze, 32'd1);
    valid_in = 1'b0;
    #1;
    chk("rst_freeze_nop", freeze, 32'd0);
    sif.ack = 1'b0;
    rst_n   = 1'b1;

    // ALU op passes straight through
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 16'h0042, 16'h0000);
    val1_in     = 16'h0007;
    add_base_in = 1'b1;
    #1;
    chk("alu_freeze", freeze, 32'd0);
    tick();
    chk("alu_res", aluRes_out, 32'h0042);
    chk("alu_wben", WB_EN_out, 32'd1);
    chk("alu_valid", valid_out, 32'd1);
    chk("alu_memdata", memData_out, 32'd0);
    chk("alu_dest", dest_out, 32'd3);
    chk("alu_val1", val1_out, 32'h0007);
    chk("alu_addbase", add_base_out, 32'd1);
    chk("alu_req", sif.req, 32'd0);
    add_base_in = 1'b0;

    // Load from 0x0010: three ACCESS cycles without ack, then ack with 0xBEEF
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 16'h0010, 16'h9999);
    #1;
    chk("ld_freeze_idle", freeze, 32'd1);
    tick();
    chk("ld_req", sif.req, 32'd1);
    chk("ld_we", sif.we, 32'd0);
    chk("ld_addr", sif.addr, 32'h0010);
    for (int i = 0; i < 3; i++) begin
      chk("ld_freeze_wait", freeze, 32'd1);
      chk("ld_bubble_valid", valid_out, 32'd0);
      chk("ld_bubble_wben", WB_EN_out, 32'd0);
      tick();
      chk("ld_addr_hold", sif.addr, 32'h0010);
    end
    sif.ack   = 1'b1;
    sif.rdata = 16'hBEEF;
    #1;
    chk("ld_freeze_ack", freeze, 32'd0);
    tick();
    sif.ack = 1'b0;
    chk("ld_memdata", memData_out, 32'hBEEF);
    chk("ld_mem_r_en", MEM_R_EN_out, 32'd1);
    chk("ld_valid", valid_out, 32'd1);
    chk("ld_wben", WB_EN_out, 32'd1);
    chk("ld_dest", dest_out, 32'd5);
    chk("ld_req_drop", sif.req, 32'd0);

    // Store 0x1234 to 0x0020, ack in the first ACCESS cycle
    set_instr(1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 16'h0020, 16'h1234);
    #1;
    chk("st_freeze_idle", freeze, 32'd1);
    tick();
    chk("st_req", sif.req, 32'd1);
    chk("st_we", sif.we, 32'd1);
    chk("st_addr", sif.addr, 32'h0020);
    chk("st_wdata", sif.wdata, 32'h1234);
    sif.ack   = 1'b1;
    sif.rdata = 16'hDEAD;
    #1;
    chk("st_freeze_ack", freeze, 32'd0);
    tick();
    sif.ack = 1'b0;
    chk("st_memdata", memData_out, 32'd0);
    chk("st_valid", valid_out, 32'd1);
    chk("st_wben", WB_EN_out, 32'd0);
    chk("st_req_drop", sif.req, 32'd0);

    // Read+write together (read wins) with no ack: abort on 5th ACCESS cycle
    set_instr(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 16'h0030, 16'h5555);
    tick();
    chk("to_req", sif.req, 32'd1);
    chk("to_we_read_prio", sif.we, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("to_memerr_early", mem_err, 32'd0);
      chk("to_freeze_wait", freeze, 32'd1);
      tick();
    end
    chk("to_memerr", mem_err, 32'd1);
    chk("to_freeze", freeze, 32'd0);
    tick();
    chk("to_memerr_pulse", mem_err, 32'd0);
    chk("to_valid", valid_out, 32'd1);
    chk("to_wben", WB_EN_out, 32'd0);
    chk("to_memdata", memData_out, 32'd0);
    chk("to_dest", dest_out, 32'd7);
    chk("to_req_drop", sif.req, 32'd0);
    chk("to_new_freeze", freeze, 32'd1);
    tick();
    chk("to_new_req", sif.req, 32'd1);

    // Reset mid-ACCESS, then a stray ack is ignored
    tick();
    rst_n    = 1'b0;
    valid_in = 1'b0;
    tick();
    chk("mrst_req", sif.req, 32'd0);
    chk("mrst_freeze", freeze, 32'd0);
    chk("mrst_valid", valid_out, 32'd0);
    rst_n     = 1'b1;
    sif.ack   = 1'b1;
    sif.rdata = 16'hAAAA;
    #1;
    chk("mrst_freeze_ack", freeze, 32'd0);
    chk("mrst_memerr", mem_err, 32'd0);
    tick();
    sif.ack = 1'b0;
    chk("mrst_memdata", memData_out, 32'd0);
    chk("mrst_req_idle", sif.req, 32'd0);

    // Ack arriving in the timeout cycle wins over the abort
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 16'h0040, 16'h0000);
    tick();
    for (int i = 0; i < 4; i++) tick();
    sif.ack   = 1'b1;
    sif.rdata = 16'h5A5A;
    #1;
    chk("race_memerr", mem_err, 32'd0);
    chk("race_freeze", freeze, 32'd0);
    tick();
    sif.ack  = 1'b0;
    valid_in = 1'b0;
    chk("race_memdata", memData_out, 32'h5A5A);
    chk("race_wben", WB_EN_out, 32'd1);
    chk("race_req_drop", sif.req, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
